// File: rtl/multicycle_ctrl.sv
// Multi-cycle datapath controller: sequences fetch, decode, execute, memory
// and write-back, drives the datapath selects and enables, runs the memory
// request handshake and traps a memory access that never completes.
module multicycle_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run_i,
  input  logic [15:0] instr_i,
  input  logic        mem_ready_i,
  input  logic        zero_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic        addr_sel_o,
  output logic        ir_we_o,
  output logic        pc_we_o,
  output logic [1:0]  pc_src_o,
  output logic        alu_a_sel_o,
  output logic [1:0]  alu_b_sel_o,
  output logic [2:0]  aluop_o,
  output logic        reg_we_o,
  output logic        reg_dst_o,
  output logic        wb_sel_o,
  output logic        halted_o,
  output logic        err_o,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_ERROR  = 3'd7
  } state_e;

  localparam logic [3:0] OP_R    = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_LW   = 4'h2;
  localparam logic [3:0] OP_SW   = 4'h3;
  localparam logic [3:0] OP_BEQ  = 4'h4;
  localparam logic [3:0] OP_JMP  = 4'h5;
  localparam logic [3:0] OP_HALT = 4'h6;

  localparam logic [2:0] ALU_IDLE = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_FUNC = 3'b100;

  state_e            state_q, state_d;
  logic [3:0]        opcode_q, opcode_d;
  logic [TO_W-1:0]   timer_q, timer_d;
  logic              to_last;

  // The request cycle that would push the timer to TIMEOUT is the last one
  // allowed; without mem_ready in that cycle the access is abandoned.
  assign to_last = (timer_q == TO_W'(TIMEOUT - 1));
  assign state_o = state_q;

  // State, latched opcode and timeout counter registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      opcode_q <= '0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      timer_q  <= timer_d;
    end
  end

  // Next-state and output decode from the current state and latched opcode.
  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    opcode_d    = opcode_q;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    addr_sel_o  = 1'b0;
    ir_we_o     = 1'b0;
    pc_we_o     = 1'b0;
    pc_src_o    = 2'b00;
    alu_a_sel_o = 1'b0;
    alu_b_sel_o = 2'b00;
    aluop_o     = ALU_IDLE;
    reg_we_o    = 1'b0;
    reg_dst_o   = 1'b0;
    wb_sel_o    = 1'b0;
    halted_o    = 1'b0;
    err_o       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (run_i) state_d = S_FETCH;
      end

      S_FETCH: begin
        mem_req_o = 1'b1;
        if (mem_ready_i) begin
          ir_we_o  = 1'b1;
          opcode_d = instr_i[15:12];
          state_d  = S_DECODE;
        end else if (to_last) begin
          state_d = S_ERROR;
        end
      end

      S_DECODE: begin
        // PC <- PC + 1 happens for every instruction, including HALT/NOP.
        alu_b_sel_o = 2'b01;
        aluop_o     = ALU_ADD;
        pc_we_o     = 1'b1;
        if (opcode_q == OP_HALT)     state_d = S_HALT;
        else if (opcode_q <= OP_JMP) state_d = S_EXEC;
        else                         state_d = S_FETCH;
      end

      S_EXEC: begin
        state_d = S_FETCH;
        case (opcode_q)
          OP_R: begin
            alu_a_sel_o = 1'b1;
            aluop_o     = ALU_FUNC;
            state_d     = S_WB;
          end
          OP_ADDI: begin
            alu_a_sel_o = 1'b1;
            alu_b_sel_o = 2'b10;
            aluop_o     = ALU_ADD;
            state_d     = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_a_sel_o = 1'b1;
            alu_b_sel_o = 2'b10;
            aluop_o     = ALU_ADD;
            state_d     = S_MEM;
          end
          OP_BEQ: begin
            alu_a_sel_o = 1'b1;
            aluop_o     = ALU_SUB;
            if (zero_i) begin
              pc_we_o  = 1'b1;
              pc_src_o = 2'b01;
            end
          end
          OP_JMP: begin
            pc_we_o  = 1'b1;
            pc_src_o = 2'b10;
          end
          default: state_d = S_FETCH;
        endcase
      end

      S_MEM: begin
        mem_req_o  = 1'b1;
        addr_sel_o = 1'b1;
        mem_we_o   = (opcode_q == OP_SW);
        if (mem_ready_i) begin
          state_d = (opcode_q == OP_SW) ? S_FETCH : S_WB;
        end else if (to_last) begin
          state_d = S_ERROR;
        end
      end

      S_WB: begin
        reg_we_o  = 1'b1;
        reg_dst_o = (opcode_q != OP_R);
        wb_sel_o  = (opcode_q == OP_LW);
        state_d   = S_FETCH;
      end

      S_HALT:  halted_o = 1'b1;
      S_ERROR: err_o    = 1'b1;

      default: state_d = S_IDLE;
    endcase
  end

  // Timeout counter: counts stalled request cycles while the FSM stays in
  // FETCH/MEM, and is zero on entry to either state.
  always_comb begin
    timer_d = '0;
    if (mem_req_o && !mem_ready_i && (state_d == state_q)) begin
      timer_d = timer_q + TO_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: a memory responder issues planned
// instructions with planned wait states, a transaction-level model predicts
// per-instruction totals, and a monitor compares what the DUT did.
module tb_multicycle_ctrl;

  localparam int TIMEOUT = 64;
  localparam int ST_IDLE = 0, ST_FETCH = 1, ST_MEM = 4, ST_HALT = 6, ST_ERROR = 7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run_i = 1'b0;
  logic [15:0] instr_i = '0;
  logic        mem_ready_i = 1'b0;
  logic        zero_i = 1'b0;
  logic        mem_req_o, mem_we_o, addr_sel_o, ir_we_o, pc_we_o;
  logic [1:0]  pc_src_o;
  logic        alu_a_sel_o;
  logic [1:0]  alu_b_sel_o;
  logic [2:0]  aluop_o;
  logic        reg_we_o, reg_dst_o, wb_sel_o, halted_o, err_o;
  logic [2:0]  state_o;
  logic [20:0] outs;

  always #5 clk = ~clk;

  multicycle_ctrl #(.TIMEOUT(TIMEOUT), .TO_W(7)) dut (
    .clk(clk), .rst_n(rst_n), .run_i(run_i), .instr_i(instr_i),
    .mem_ready_i(mem_ready_i), .zero_i(zero_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .addr_sel_o(addr_sel_o),
    .ir_we_o(ir_we_o), .pc_we_o(pc_we_o), .pc_src_o(pc_src_o),
    .alu_a_sel_o(alu_a_sel_o), .alu_b_sel_o(alu_b_sel_o), .aluop_o(aluop_o),
    .reg_we_o(reg_we_o), .reg_dst_o(reg_dst_o), .wb_sel_o(wb_sel_o),
    .halted_o(halted_o), .err_o(err_o), .state_o(state_o)
  );

  assign outs = {mem_req_o, mem_we_o, addr_sel_o, ir_we_o, pc_we_o, pc_src_o,
                 alu_a_sel_o, alu_b_sel_o, aluop_o, reg_we_o, reg_dst_o,
                 wb_sel_o, halted_o, err_o, state_o};

  typedef struct {
    logic [3:0] op;
    int         w_fetch;  // not-ready cycles before mem_ready in FETCH
    int         w_mem;    // not-ready cycles before mem_ready in MEM
    logic       zero;
  } plan_t;

  // Per-instruction totals, from FETCH entry up to the next FETCH/HALT/ERROR.
  typedef struct {
    int         cycles, mem_req, mem_we, ir_we, pc_we, alu_a, addr_sel, reg_we, alu_bad;
    logic [1:0] pc_src_or;
    logic [2:0] alu_or;
    logic [1:0] alu_b_or;
    logic       reg_dst_or, wb_sel_or;
    int         end_state;
  } txn_t;

  plan_t plan_q[$];
  txn_t  exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    txn_id = 0;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, want);
    end
  endtask

  function automatic plan_t mk(input int op, input int wf, input int wm, input bit z);
    plan_t p;
    p.op = 4'(op); p.w_fetch = wf; p.w_mem = wm; p.zero = z;
    return p;
  endfunction

  // Reference model: instruction-level totals derived from the sequencing rules.
  function automatic txn_t model(input plan_t p);
    txn_t e;
    bit   ls;
    e = '{default: 0};
    if (p.w_fetch >= TIMEOUT) begin
      e.cycles = TIMEOUT; e.mem_req = TIMEOUT; e.end_state = ST_ERROR;
      return e;
    end
    e.cycles = p.w_fetch + 2;          // fetch + decode
    e.mem_req = p.w_fetch + 1;
    e.ir_we = 1; e.pc_we = 1; e.alu_or = 3'b001; e.alu_b_or = 2'b01;
    if (p.op == 4'h6) begin e.end_state = ST_HALT; return e; end
    e.end_state = ST_FETCH;
    if (p.op > 4'h6) return e;         // NOP
    e.cycles += 1;                     // execute
    if (p.op <= 4'h4) e.alu_a = 1;
    case (p.op)
      4'h0: e.alu_or |= 3'b100;
      4'h1, 4'h2, 4'h3: begin e.alu_or |= 3'b001; e.alu_b_or |= 2'b10; end
      4'h4: begin
        e.alu_or |= 3'b010;
        if (p.zero) begin e.pc_we += 1; e.pc_src_or = 2'b01; end
      end
      default: begin e.pc_we += 1; e.pc_src_or = 2'b10; end
    endcase
    ls = (p.op == 4'h2) || (p.op == 4'h3);
    if (ls) begin
      int n;
      n = (p.w_mem >= TIMEOUT) ? TIMEOUT : p.w_mem + 1;
      e.cycles += n; e.mem_req += n; e.addr_sel = n;
      if (p.op == 4'h3) e.mem_we = n;
      if (p.w_mem >= TIMEOUT) begin e.end_state = ST_ERROR; return e; end
    end
    if (p.op <= 4'h2) begin
      e.cycles += 1; e.reg_we = 1;
      e.reg_dst_or = (p.op != 4'h0);
      e.wb_sel_or = (p.op == 4'h2);
    end
    return e;
  endfunction

  // Memory responder: pops the next plan at the start of each fetch, pushes
  // its prediction, and answers requests after the planned wait.
  int    wait_cnt = 0;
  plan_t cur;
  always @(negedge clk) begin
    if (!rst_n) begin
      wait_cnt = 0;
      mem_ready_i = 1'b0;
    end else if (mem_req_o) begin
      if (!addr_sel_o && wait_cnt == 0) begin
        if (plan_q.size() > 0) cur = plan_q.pop_front();
        else cur = mk(6, 0, 0, 1'b0);
        zero_i = cur.zero;
        exp_q.push_back(model(cur));
      end
      if (wait_cnt == (addr_sel_o ? cur.w_mem : cur.w_fetch)) begin
        mem_ready_i = 1'b1;
        instr_i = {cur.op, 12'($urandom)};
        wait_cnt = 0;
      end else begin
        mem_ready_i = 1'b0;
        instr_i = 16'($urandom);
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
      mem_ready_i = 1'($urandom_range(0, 1));  // must be ignored
      instr_i = 16'($urandom);
    end
  end

  task automatic cmp_txn(input txn_t o);
    txn_t  e;
    string t;
    t = $sformatf("txn%0d", txn_id);
    txn_id++;
    if (exp_q.size() == 0) begin
      check({t, "_expected_available"}, 0, 1);
      return;
    end
    e = exp_q.pop_front();
    check({t, "_cycles"}, o.cycles, e.cycles);
    check({t, "_mem_req"}, o.mem_req, e.mem_req);
    check({t, "_mem_we"}, o.mem_we, e.mem_we);
    check({t, "_ir_we"}, o.ir_we, e.ir_we);
    check({t, "_pc_we"}, o.pc_we, e.pc_we);
    check({t, "_pc_src"}, int'(o.pc_src_or), int'(e.pc_src_or));
    check({t, "_aluop_bits"}, int'(o.alu_or), int'(e.alu_or));
    check({t, "_aluop_multibit"}, o.alu_bad, 0);
    check({t, "_alu_a_sel"}, o.alu_a, e.alu_a);
    check({t, "_alu_b_sel"}, int'(o.alu_b_or), int'(e.alu_b_or));
    check({t, "_addr_sel"}, o.addr_sel, e.addr_sel);
    check({t, "_reg_we"}, o.reg_we, e.reg_we);
    check({t, "_reg_dst"}, int'(o.reg_dst_or), int'(e.reg_dst_or));
    check({t, "_wb_sel"}, int'(o.wb_sel_or), int'(e.wb_sel_or));
    check({t, "_end_state"}, o.end_state, e.end_state);
  endtask

  // Monitor: frames instructions on FETCH entry and accumulates outputs.
  txn_t obs;
  bit   in_txn = 1'b0;
  int   prev_state = 0;
  int   st;
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      in_txn = 1'b0;
      prev_state = ST_IDLE;
    end else begin
      st = int'(state_o);
      if (in_txn && ((st == ST_FETCH && prev_state != ST_FETCH) ||
                     st == ST_HALT || st == ST_ERROR)) begin
        obs.end_state = st;
        cmp_txn(obs);
        in_txn = 1'b0;
      end
      if (st == ST_FETCH && prev_state != ST_FETCH) begin
        obs = '{default: 0};
        in_txn = 1'b1;
      end
      if (in_txn) begin
        obs.cycles++;
        obs.mem_req += int'(mem_req_o);
        obs.mem_we += int'(mem_we_o);
        obs.ir_we += int'(ir_we_o);
        obs.pc_we += int'(pc_we_o);
        obs.pc_src_or |= pc_src_o;
        obs.alu_or |= aluop_o;
        if ($countones(aluop_o) > 1) obs.alu_bad++;
        obs.alu_b_or |= alu_b_sel_o;
        obs.alu_a += int'(alu_a_sel_o);
        obs.addr_sel += int'(addr_sel_o);
        obs.reg_we += int'(reg_we_o);
        obs.reg_dst_or |= reg_dst_o;
        obs.wb_sel_or |= wb_sel_o;
      end
      prev_state = st;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #3 rst_n = 1'b0;
    plan_q.delete();
    @(negedge clk);
    exp_q.delete();
    @(negedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic start_run();
    @(negedge clk);
    #3 run_i = 1'b1;
    @(negedge clk);
    #3 run_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values while rst_n is low.
    repeat (2) @(negedge clk);
    #3;
    check("reset_outputs", int'(outs), 0);
    check("reset_state", int'(state_o), ST_IDLE);

    // Directed program head, random middle, HALT at the end.
    plan_q.push_back(mk(0, 0, 0, 0));      // R, zero-wait
    plan_q.push_back(mk(2, 2, 2, 0));      // LW, ready on 3rd request cycle
    plan_q.push_back(mk(4, 0, 0, 1));      // BEQ taken
    plan_q.push_back(mk(4, 0, 0, 0));      // BEQ not taken
    plan_q.push_back(mk(5, 1, 0, 0));      // JMP
    plan_q.push_back(mk(15, 0, 0, 0));     // NOP
    plan_q.push_back(mk(1, 1, 0, 1));      // ADDI
    plan_q.push_back(mk(3, 0, 63, 0));     // SW, ready on last allowed cycle
    plan_q.push_back(mk(0, 63, 0, 0));     // R, fetch ready on last allowed cycle
    for (int i = 0; i < 30; i++) begin
      plan_t p;
      int    op;
      op = $urandom_range(0, 15);
      if (op == 6) op = 7;
      p = mk(op,
             ($urandom_range(0, 9) == 0) ? 63 : $urandom_range(0, 3),
             ($urandom_range(0, 9) == 0) ? 63 : $urandom_range(0, 3),
             1'($urandom_range(0, 1)));
      plan_q.push_back(p);
    end
    plan_q.push_back(mk(6, 1, 0, 0));      // HALT

    @(negedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    #3 run_i = 1'b1;
    for (int c = 0; c < 20000 && !halted_o; c++) begin
      @(negedge clk);
      #3 run_i = 1'($urandom_range(0, 1));
    end
    check("halt_reached", int'(halted_o), 1);
    repeat (2) @(negedge clk);
    check("expected_drained", exp_q.size(), 0);
    check("plan_consumed", plan_q.size(), 0);

    // HALT is sticky regardless of run.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #3 run_i = ~run_i;
      check($sformatf("halt_sticky_%0d", c), int'(outs),
            (1 << 4) | ST_HALT);
    end

    // Asynchronous reset in the middle of a stalled SW access.
    run_i = 1'b0;
    do_reset();
    plan_q.push_back(mk(3, 0, 20, 0));
    start_run();
    for (int c = 0; c < 50 && int'(state_o) != ST_MEM; c++) @(negedge clk);
    repeat (3) @(negedge clk);
    #3;
    check("sw_mem_req_before_reset", int'({mem_req_o, mem_we_o, addr_sel_o}), 7);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", int'(outs), 0);
    @(negedge clk);
    exp_q.delete();
    #3;
    check("reset_hold_outputs", int'(outs), 0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    #3;
    check("idle_waits_for_run", int'(outs), ST_IDLE);

    // Fetch never answered: ERROR after TIMEOUT request cycles.
    plan_q.push_back(mk(0, TIMEOUT, 0, 0));
    start_run();
    for (int c = 0; c < 200 && !err_o; c++) @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #3 run_i = ~run_i;
      check($sformatf("err_sticky_%0d", c), int'(outs), (1 << 3) | ST_ERROR);
    end

    // Data access never answered: ERROR from MEM.
    run_i = 1'b0;
    do_reset();
    plan_q.push_back(mk(2, 0, TIMEOUT, 0));
    start_run();
    for (int c = 0; c < 200 && !err_o; c++) @(negedge clk);
    repeat (2) @(negedge clk);
    #3;
    check("mem_timeout_outputs", int'(outs), (1 << 3) | ST_ERROR);
    check("final_expected_drained", exp_q.size(), 0);
    check("transactions_seen", txn_id, 42);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
